// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU control path: ISA opcodes, phase
// encoding and the decode helper used by the sequencer.
package cpu_pkg;

  localparam int OPC_W = 3;
  localparam int PH_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PH_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input logic [OPC_W-1:0] opc);
    logic res;
    case (opc)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: res = 1'b1;
      default:                        res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer (master) and the CPU datapath (slave).
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             sel;
  logic             rd;
  logic             ld_ir;
  logic             inc_pc;
  logic             ld_pc;
  logic             ld_ac;
  logic             wr;
  logic             data_e;
  logic             halt;
  logic [PH_W-1:0]  phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

endinterface

// File: rtl/cpu_sequencer_phase_ctr.sv
// Instruction-cycle phase counter: free-running modulo-8 with a hold enable,
// cleared by synchronous active-high reset.
module seq_phase_ctr
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  output logic [PH_W-1:0] o_phase
);

  logic [PH_W-1:0] r_phase;

  // Phase register: reset to the first phase, otherwise advance when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_INST_ADDR;
    end else if (i_en) begin
      r_phase <= r_phase + PH_W'(1);
    end else begin
      r_phase <= r_phase;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/cpu_sequencer.sv
// Central control FSM of the 8-bit accumulator CPU: steps the 8-phase
// instruction cycle and decodes the opcode into datapath strobes.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.master bus
);

  logic [PH_W-1:0] w_phase;
  logic            r_halted;
  logic            w_halt_entry;
  logic            w_ctr_en;
  logic            w_aluop;
  logic            w_hlt;
  logic            w_skz;
  logic            w_sto;
  logic            w_jmp;

  assign w_aluop      = is_aluop(bus.opcode);
  assign w_hlt        = (bus.opcode == OP_HLT);
  assign w_skz        = (bus.opcode == OP_SKZ);
  assign w_sto        = (bus.opcode == OP_STO);
  assign w_jmp        = (bus.opcode == OP_JMP);
  assign w_halt_entry = !r_halted && (w_phase == PH_OP_ADDR) && w_hlt;
  // Phase freezes at OP_ADDR on the edge that enters halt, and stays there.
  assign w_ctr_en     = !(r_halted || w_halt_entry);

  seq_phase_ctr u_phase_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ctr_en),
    .o_phase (w_phase)
  );

  // Halted flag: set on HLT in OP_ADDR, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_halt_entry) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  // Strobe decode from phase, opcode, zero flag and halted state.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (r_halted) begin
      bus.halt = 1'b1;
    end else begin
      case (w_phase)
        PH_INST_ADDR: begin
          bus.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          bus.inc_pc = !w_hlt;
          bus.halt   = w_hlt;
        end
        PH_OP_FETCH: begin
          bus.rd = w_aluop;
        end
        PH_ALU_OP: begin
          bus.rd     = w_aluop;
          bus.inc_pc = w_skz && bus.zero;
          bus.ld_pc  = w_jmp;
          bus.data_e = w_sto;
        end
        PH_STORE: begin
          bus.rd     = w_aluop;
          bus.ld_ac  = w_aluop;
          bus.ld_pc  = w_jmp;
          bus.wr     = w_sto;
          bus.data_e = w_sto;
        end
        default: begin
          bus.sel = 1'b0;
        end
      endcase
    end
  end

  assign bus.phase = w_phase;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a cycle model built from the phase
// table checks every cycle, and directed instruction cycles pin literal values.
module tb_cpu_sequencer;

  logic clk;
  logic rst;
  cpu_sequencer_if u_if ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_phase  = 0;
  bit m_halted = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}.
  function automatic logic [8:0] model_strobes(input int ph, input int opc,
                                               input bit z, input bit hl);
    bit alu;
    bit s_sel, s_rd, s_ir, s_inc, s_pc, s_ac, s_wr, s_de, s_halt;
    alu    = (opc >= 2) && (opc <= 5);
    s_sel  = !hl && (ph <= 3);
    s_rd   = !hl && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu));
    s_ir   = !hl && (ph == 2 || ph == 3);
    s_inc  = !hl && ((ph == 4 && opc != 0) || (ph == 6 && opc == 1 && z));
    s_pc   = !hl && (ph >= 6) && (opc == 7);
    s_ac   = !hl && (ph == 7) && alu;
    s_wr   = !hl && (ph == 7) && (opc == 6);
    s_de   = !hl && (ph >= 6) && (opc == 6);
    s_halt = hl || (ph == 4 && opc == 0);
    return {s_sel, s_rd, s_ir, s_inc, s_pc, s_ac, s_wr, s_de, s_halt};
  endfunction

  // Model state: advance one phase per cycle, halt on HLT in phase 4.
  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 4 && u_if.opcode == 3'd0) m_halted <= 1'b1;
      else m_phase <= (m_phase + 1) % 8;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", int'(u_if.phase), m_phase);
      check("strobes",
            int'({u_if.sel, u_if.rd, u_if.ld_ir, u_if.inc_pc, u_if.ld_pc,
                  u_if.ld_ac, u_if.wr, u_if.data_e, u_if.halt}),
            int'(model_strobes(m_phase, int'(u_if.opcode), u_if.zero, m_halted)));
      check("ld_pc_inc_pc_excl", int'(u_if.ld_pc & u_if.inc_pc), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One full instruction cycle from phase 0, checking hand-written phase masks.
  task automatic run_instr(input string nm, input logic [2:0] opc, input logic z,
                           input logic [7:0] e_rd, input logic [7:0] e_inc,
                           input logic [7:0] e_pc, input logic [7:0] e_wr,
                           input logic [7:0] e_de, input logic [7:0] e_ac);
    u_if.opcode = opc;
    u_if.zero   = z;
    for (int p = 0; p < 8; p++) begin
      check({nm, "_phase"}, int'(u_if.phase), p);
      check({nm, "_sel"},    int'(u_if.sel),    (p <= 3) ? 1 : 0);
      check({nm, "_ld_ir"},  int'(u_if.ld_ir),  (p == 2 || p == 3) ? 1 : 0);
      check({nm, "_rd"},     int'(u_if.rd),     int'(e_rd[p]));
      check({nm, "_inc_pc"}, int'(u_if.inc_pc), int'(e_inc[p]));
      check({nm, "_ld_pc"},  int'(u_if.ld_pc),  int'(e_pc[p]));
      check({nm, "_wr"},     int'(u_if.wr),     int'(e_wr[p]));
      check({nm, "_data_e"}, int'(u_if.data_e), int'(e_de[p]));
      check({nm, "_ld_ac"},  int'(u_if.ld_ac),  int'(e_ac[p]));
      step();
    end
    check({nm, "_wrap"}, int'(u_if.phase), 0);
  endtask

  initial begin
    rst         = 1'b0;
    u_if.opcode = 3'd5;
    u_if.zero   = 1'b0;
    step();
    do_reset();
    chk_en = 1'b1;

    check("rst_phase", int'(u_if.phase), 0);
    check("rst_sel",   int'(u_if.sel), 1);
    check("rst_halt",  int'(u_if.halt), 0);
    check("rst_rd",    int'(u_if.rd), 0);

    //         name    opc    z     rd          inc         ld_pc       wr          data_e      ld_ac
    run_instr("lda",   3'd5, 1'b0, 8'b11101110, 8'b00010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b10000000);
    run_instr("sto",   3'd6, 1'b0, 8'b00001110, 8'b00010000, 8'b00000000, 8'b10000000, 8'b11000000, 8'b00000000);
    run_instr("skz_z1",3'd1, 1'b1, 8'b00001110, 8'b01010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000);
    run_instr("skz_z0",3'd1, 1'b0, 8'b00001110, 8'b00010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000);
    run_instr("jmp",   3'd7, 1'b1, 8'b00001110, 8'b00010000, 8'b11000000, 8'b00000000, 8'b00000000, 8'b00000000);
    run_instr("add",   3'd2, 1'b1, 8'b11101110, 8'b00010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b10000000);
    run_instr("xor",   3'd4, 1'b0, 8'b11101110, 8'b00010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b10000000);

    // HLT: halt appears in phase 4 and the machine freezes there.
    u_if.opcode = 3'd0;
    for (int i = 0; i < 4; i++) step();
    check("hlt_enter_phase", int'(u_if.phase), 4);
    check("hlt_enter_halt",  int'(u_if.halt), 1);
    check("hlt_enter_inc",   int'(u_if.inc_pc), 0);
    for (int i = 0; i < 20; i++) step();
    check("hlt_hold_phase", int'(u_if.phase), 4);
    check("hlt_hold_halt",  int'(u_if.halt), 1);
    check("hlt_hold_other",
          int'({u_if.sel, u_if.rd, u_if.inc_pc, u_if.ld_pc, u_if.ld_ac, u_if.wr, u_if.data_e}), 0);
    u_if.opcode = 3'd5;
    check("hlt_hold_opc_chg", int'(u_if.phase), 4);
    do_reset();
    check("hlt_rst_phase", int'(u_if.phase), 0);
    check("hlt_rst_halt",  int'(u_if.halt), 0);
    check("hlt_rst_sel",   int'(u_if.sel), 1);

    // Reset in the middle of a store, in phase 6.
    u_if.opcode = 3'd6;
    for (int i = 0; i < 6; i++) step();
    check("midrst_pre_phase",  int'(u_if.phase), 6);
    check("midrst_pre_data_e", int'(u_if.data_e), 1);
    do_reset();
    check("midrst_phase",  int'(u_if.phase), 0);
    check("midrst_wr",     int'(u_if.wr), 0);
    check("midrst_data_e", int'(u_if.data_e), 0);
    run_instr("sto_again", 3'd6, 1'b0, 8'b00001110, 8'b00010000, 8'b00000000, 8'b10000000, 8'b11000000, 8'b00000000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Central control FSM for the 8-bit accumulator CPU.
- Steps an 8-phase instruction cycle and decodes the 3-bit opcode held in the instruction register.
- Drives every datapath control strobe: address mux select, memory read/write, IR/AC/PC loads, PC increment, data bus enable.
- Sits between the instruction register output and the 8-bit register, mux, counter and memory instances of the CPU top level.

Parameters:
- OPC_W, 3, opcode width. Fixed by the ISA; the parameter exists for package-constant consistency only.
- PH_W, 3, phase counter width; 2**PH_W = 8 phases.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- opcode  input  OPC_W  IR[7:5]; stable from INST_LOAD through STORE.
- zero  input  1  accumulator-zero flag from the ALU.
- sel  output  1  address mux select: 1 = PC, 0 = IR operand.
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- ld_pc  output  1  program counter load (jump).
- ld_ac  output  1  accumulator load.
- wr  output  1  memory write strobe.
- data_e  output  1  accumulator-to-data-bus tri-state enable.
- halt  output  1  CPU halted indicator.
- phase  output  PH_W  current phase (debug/observability).

Behaviour:
- State: 3-bit phase register plus 1-bit halted flag.
- Phases in order: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Phase advance: +1 each cycle, wrapping 7 -> 0 unless halted.
- Reset: when rst=1 at an edge, phase <= INST_ADDR and halted <= 0, whether mid-instruction or halted. Reset wins over all other events.
- Resulting values after reset: sel=1, all other strobes 0, halt=0, phase=0.
- Outputs are combinational from phase, opcode, zero and halted, so each strobe is valid in the same cycle as its phase. No registered latency.
- Decode terms: ALUOP = opcode in {ADD=2, AND=3, XOR=4, LDA=5}. HLT=0, SKZ=1, STO=6, JMP=7.
- Output table; any strobe not listed is 0 in that phase:
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc = !HLT; halt = HLT.
  - OP_FETCH: rd = ALUOP.
  - ALU_OP: rd = ALUOP; inc_pc = SKZ & zero; ld_pc = JMP; data_e = STO.
  - STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO.
- Halt entry: in OP_ADDR with opcode=HLT, the next edge sets halted=1 and phase holds at OP_ADDR.
- While halted:
  - halt=1 and all other strobes 0, including inc_pc and sel.
  - phase frozen at 4.
  - Exit only by rst.
- SKZ with zero=0: no strobes in ALU_OP or STORE; execution continues to the next instruction.
- wr pulses exactly one cycle per STO instruction. data_e spans ALU_OP and STORE so the bus is driven before and during wr.
- ld_pc and inc_pc are never asserted in the same cycle. A legal opcode cannot produce this by construction; verification asserts it.
- Unknown or X opcode is not a supported case. All 8 opcodes are defined.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_HLT..OP_JMP;
  - phase constants PH_INST_ADDR..PH_STORE;
  - OPC_W and PH_W.
- One sub-module, seq_phase_ctr: 3-bit counter with sync active-high reset and hold enable (enable = !halted). The output decode stays in cpu_sequencer.

Test Plan:
- Reset then 8 cycles with opcode=LDA(5) -> phase runs 0..7, then 0 on cycle 9. rd=1 in phases 1,2,3,5,6,7; ld_ir=1 in phases 2,3; inc_pc=1 in phase 4 only; ld_ac=1 in phase 7 only; sel=1 in phases 0-3.
- opcode=STO(6) for one full cycle -> data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 and ld_ac=0 throughout phases 4-7.
- opcode=SKZ(1): run once with zero=1 and once with zero=0. With zero=1, inc_pc=1 in phases 4 and 6. With zero=0, inc_pc=1 in phase 4 only.
- opcode=JMP(7) -> ld_pc=1 in phases 6 and 7; inc_pc=1 in phase 4; wr=0 throughout.
- opcode=HLT(0) -> halt=1 from phase 4. After 20 further cycles phase still =4, halt=1, and sel, rd, inc_pc, ld_pc, ld_ac, wr, data_e all 0. Assert rst for one cycle -> phase=0, halt=0, sel=1.
- rst asserted mid-instruction in phase 6 with opcode=STO -> next cycle phase=0, wr=0, data_e=0. The full 8-phase sequence then restarts cleanly.
